wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Write-back arbiter for the single write port (WE3/A3/WD3) of the 32-entry register file. Two producers compete for that port: the ALU result path and the memory load path. Each producer hands off results over its own valid/ready channel into a small private FIFO. The arbiter drains one entry per cycle into registered `RegWrite`/`rd`/`wdata` outputs, which drive the register file directly, and can optionally track pending destinations for hazard detection.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: register data width.
- `REG_DATA_WIDTH`, default 5: register address width; the register file has 2**REG_DATA_WIDTH entries.
- `FIFO_DEPTH`, default 2: entries per producer FIFO; must be a power of two and at least 2.

Ports:
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `alu_valid`, in, 1: ALU result offered.
- `alu_ready`, out, 1: ALU FIFO can accept.
- `alu_rd`, in, REG_DATA_WIDTH: ALU destination register.
- `alu_data`, in, DATA_WIDTH: ALU result.
- `mem_valid`, in, 1: load result offered.
- `mem_ready`, out, 1: memory FIFO can accept.
- `mem_rd`, in, REG_DATA_WIDTH: load destination register.
- `mem_data`, in, DATA_WIDTH: load data.
- `RegWrite`, out, 1: to register file WE3.
- `rd`, out, REG_DATA_WIDTH: to register file A3.
- `wdata`, out, DATA_WIDTH: to register file WD3.
- `pending`, out, 2**REG_DATA_WIDTH: bit r set means a write to register r is in flight.
- `idle`, out, 1: both FIFOs empty and `RegWrite` low.

## Operation
- **Accept.** A handshake occurs on a rising edge where `x_valid && x_ready`. The pair {rd, data} is pushed into FIFO x.
- **Ready.** `x_ready = !full_x`. It is combinational from the occupancy count and does not depend on `x_valid`.
- **Full-FIFO push.** A push and a pop of the same FIFO in the same edge is legal. However, a full FIFO does not assert ready even if it is being popped that edge (no pass-through).
- **Arbitration.** Evaluated each edge over the FIFO heads:
  - Neither FIFO non-empty: no grant.
  - One FIFO non-empty: that FIFO is granted.
  - Both non-empty: round-robin. The producer not granted last time wins.
  - The `last_grant` register updates only on contested or uncontested grants. It never updates when there is no grant.
- **Pop.** The granted head is popped and registered onto `rd`/`wdata`.
  - `RegWrite <= (head_rd != 0)`. Writes to x0 are consumed silently: `RegWrite` is 0, but `rd`/`wdata` still update.
  - When there is no grant, `RegWrite <= 0` and `rd`/`wdata` hold their values.
- **Ordering.** Order within one producer is preserved. Order between producers is not guaranteed. Upstream must not issue a second write to an rd whose `pending` bit is set from the other producer.
- **Idle.** `idle = empty_alu && empty_mem && !RegWrite`.

## Timing
- **Reset values.** While `rst` is high:
  - FIFOs are empty; `alu_ready` and `mem_ready` are 0.
  - `RegWrite`, `rd`, `wdata` and `pending` are 0.
  - `last_grant` = ALU, so the memory path wins the first contest.
  - `idle` is 1.
- **Reset mid-operation.** All queued entries are discarded with no write issued, and all `pending` bits clear immediately.
- **After reset.** On the first edge after `rst` falls, ready goes high as soon as the FIFO is non-full.
- **Latency.** For a handshake at edge k with the FIFO otherwise empty and uncontested:
  - Pop occurs at edge k+1.
  - `RegWrite`/`rd`/`wdata` are valid during cycle k+1..k+2.
  - The register file writes at edge k+2.
- **Contention.** Each contested edge delays the loser by exactly 1 cycle.
- **Throughput.** Sustained throughput is 1 write per cycle total. Each producer gets at least 1 write in 2 cycles under constant contention.
- **Full FIFO.** `FIFO_DEPTH` entries queued means ready is 0 that cycle. Ready returns the cycle after a pop.

## Configuration
- Macro `WB_SCOREBOARD_EN` controls the `pending` scoreboard.
- **Defined:**
  - One counter per register, width clog2(2*FIFO_DEPTH+2).
  - Increment on accept with rd != 0.
  - Decrement at the edge where the register file performs that write, i.e. the edge after `RegWrite` is raised for it.
  - If an increment and a decrement hit the same counter on the same edge, the counter is unchanged.
  - `pending[r] = (cnt[r] != 0)`.
  - `pending[0]` is always 0.
- **Undefined:** `pending` is tied to all zeros and no counters are built.

## Test plan
- **Reset.** Assert `rst` asynchronously mid-cycle with 2 ALU entries queued → ready, `RegWrite` and `pending` drop at once. After release, no write to those registers ever occurs and `idle` is 1.
- **Single ALU write.** ALU push {rd=5, data=0xDEADBEEF} at edge k → `RegWrite`=1, `rd`=5, `wdata`=0xDEADBEEF during cycle k+1; `RegWrite`=0 during cycle k+2. With `WB_SCOREBOARD_EN`, `pending[5]` is 1 from k to k+2, then 0.
- **Simultaneous pushes.** ALU {rd=3, 0x11} and MEM {rd=4, 0x22} pushed on the same edge after reset → MEM writes first (rd=4), ALU writes the next cycle (rd=3). A repeated simultaneous pair then alternates ALU first.
- **Backpressure.** Hold `mem_valid` high for 4 consecutive entries with FIFO_DEPTH=2 while ALU saturates → `mem_ready` deasserts after 2 unpopped entries. All 4 loads are written in push order with no loss or duplication.
- **x0 write.** ALU push {rd=0, data=0x1234} → `RegWrite` stays 0, `rd`=0 and `wdata`=0x1234 for one cycle, and `pending` is unchanged.
- **Duplicate rd.** With `WB_SCOREBOARD_EN`, three back-to-back ALU pushes to rd=7 → `pending[7]` stays 1 until the edge after the third write, then clears.

Source files
------------

// File: rtl/wb_arbiter.sv
// wb_arbiter: write-back arbiter for the single register-file write port.
// ALU and load results enter private FIFOs over valid/ready channels; one
// FIFO head per cycle is drained (round-robin when both have data) into
// registered RegWrite/rd/wdata outputs.
// Optional macro WB_SCOREBOARD_EN builds per-register in-flight counters that
// drive `pending`; with the macro undefined `pending` is all zeros.

// Small synchronous FIFO holding {rd, data} pairs for one producer.
module wb_arbiter_fifo #(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [AW-1:0] rd_i,
    input  logic [DW-1:0] data_i,
    output logic [AW-1:0] rd_o,
    output logic [DW-1:0] data_o,
    output logic          empty_o,
    output logic          full_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] cnt_q;
    logic [AW-1:0] rd_mem_q   [DEPTH];
    logic [DW-1:0] data_mem_q [DEPTH];

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap freely.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + PW'(1);
            if (pop_i)  rptr_q <= rptr_q + PW'(1);
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Entry storage; contents are don't-care while the slot is empty.
    always_ff @(posedge clk) begin
        if (push_i) begin
            rd_mem_q[wptr_q]   <= rd_i;
            data_mem_q[wptr_q] <= data_i;
        end
    end

    assign rd_o    = rd_mem_q[rptr_q];
    assign data_o  = data_mem_q[rptr_q];
    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
endmodule

module wb_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_DATA_WIDTH = 5,
    parameter int FIFO_DEPTH     = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         alu_valid,
    output logic                         alu_ready,
    input  logic [REG_DATA_WIDTH-1:0]    alu_rd,
    input  logic [DATA_WIDTH-1:0]        alu_data,
    input  logic                         mem_valid,
    output logic                         mem_ready,
    input  logic [REG_DATA_WIDTH-1:0]    mem_rd,
    input  logic [DATA_WIDTH-1:0]        mem_data,
    output logic                         RegWrite,
    output logic [REG_DATA_WIDTH-1:0]    rd,
    output logic [DATA_WIDTH-1:0]        wdata,
    output logic [2**REG_DATA_WIDTH-1:0] pending,
    output logic                         idle
);
    localparam int RW   = REG_DATA_WIDTH;
    localparam int NREG = 2**REG_DATA_WIDTH;

    typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1} src_e;

    logic          alu_push, mem_push, gnt_alu, gnt_mem;
    logic          alu_empty, alu_full, mem_empty, mem_full;
    logic [RW-1:0] alu_head_rd, mem_head_rd;
    logic [DATA_WIDTH-1:0] alu_head_data, mem_head_data;

    src_e                  last_q, last_d;
    logic                  regwrite_q, regwrite_d;
    logic [RW-1:0]         rd_q, rd_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    // Ready is held low during reset; no pass-through on a full FIFO.
    assign alu_ready = !alu_full && !rst;
    assign mem_ready = !mem_full && !rst;
    assign alu_push  = alu_valid && alu_ready;
    assign mem_push  = mem_valid && mem_ready;

    wb_arbiter_fifo #(.DW(DATA_WIDTH), .AW(RW), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
        .clk(clk), .rst(rst), .push_i(alu_push), .pop_i(gnt_alu),
        .rd_i(alu_rd), .data_i(alu_data), .rd_o(alu_head_rd), .data_o(alu_head_data),
        .empty_o(alu_empty), .full_o(alu_full)
    );

    wb_arbiter_fifo #(.DW(DATA_WIDTH), .AW(RW), .DEPTH(FIFO_DEPTH)) u_mem_fifo (
        .clk(clk), .rst(rst), .push_i(mem_push), .pop_i(gnt_mem),
        .rd_i(mem_rd), .data_i(mem_data), .rd_o(mem_head_rd), .data_o(mem_head_data),
        .empty_o(mem_empty), .full_o(mem_full)
    );

    // Round-robin: on contest the producer not granted last time wins.
    assign gnt_alu = !alu_empty && (mem_empty || last_q == SRC_MEM);
    assign gnt_mem = !mem_empty && (alu_empty || last_q == SRC_ALU);

    // Next write-port state: x0 writes update rd/wdata but never raise RegWrite.
    always_comb begin
        last_d     = last_q;
        regwrite_d = 1'b0;
        rd_d       = rd_q;
        wdata_d    = wdata_q;
        if (gnt_alu) begin
            last_d     = SRC_ALU;
            regwrite_d = (alu_head_rd != '0);
            rd_d       = alu_head_rd;
            wdata_d    = alu_head_data;
        end else if (gnt_mem) begin
            last_d     = SRC_MEM;
            regwrite_d = (mem_head_rd != '0);
            rd_d       = mem_head_rd;
            wdata_d    = mem_head_data;
        end
    end

    // Registered write port and grant history; reset makes MEM win first contest.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q     <= SRC_ALU;
            regwrite_q <= 1'b0;
            rd_q       <= '0;
            wdata_q    <= '0;
        end else begin
            last_q     <= last_d;
            regwrite_q <= regwrite_d;
            rd_q       <= rd_d;
            wdata_q    <= wdata_d;
        end
    end

    assign RegWrite = regwrite_q;
    assign rd       = rd_q;
    assign wdata    = wdata_q;
    assign idle     = alu_empty && mem_empty && !regwrite_q;

`ifdef WB_SCOREBOARD_EN
    // Worst case per register: both FIFOs full plus the write on the port.
    localparam int CNTW = $clog2(2*FIFO_DEPTH + 2);

    logic [CNTW-1:0] cnt_q [NREG];
    logic [CNTW-1:0] cnt_d [NREG];

    // Net count change: accepts add, the register-file write edge subtracts.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r]
                     + CNTW'(alu_push && alu_rd == RW'(r))
                     + CNTW'(mem_push && mem_rd == RW'(r))
                     - CNTW'(regwrite_q && rd_q == RW'(r));
        end
        cnt_d[0] = '0;
    end

    // In-flight counters; reset discards everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
        end
    end

    // A register is pending while any write to it is queued or on the port.
    always_comb begin
        pending = '0;
        for (int r = 1; r < NREG; r++) pending[r] = (cnt_q[r] != '0);
    end
`else
    assign pending = '0;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed timing checks per scenario plus
// a per-producer scoreboard that matches every RegWrite against queued pushes.
module tb_wb_arbiter;
`ifdef WB_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0, mem_valid = 1'b0;
    logic        alu_ready, mem_ready;
    logic [4:0]  alu_rd = '0, mem_rd = '0;
    logic [31:0] alu_data = '0, mem_data = '0;
    logic        RegWrite, idle;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic [31:0] pending;

    int  n_vec = 0;
    int  n_err = 0;
    bit  mon_en = 1'b0;
    wr_t q_alu[$];
    wr_t q_mem[$];

    wb_arbiter dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .RegWrite(RegWrite), .rd(rd), .wdata(wdata), .pending(pending), .idle(idle)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    // Scoreboard: each register-file write must match the head of one producer queue.
    always @(negedge clk) begin
        if (mon_en && !rst && RegWrite) begin
            n_vec++;
            if (q_alu.size() > 0 && q_alu[0].rd == rd && q_alu[0].data == wdata)
                void'(q_alu.pop_front());
            else if (q_mem.size() > 0 && q_mem[0].rd == rd && q_mem[0].data == wdata)
                void'(q_mem.pop_front());
            else begin
                n_err++;
                $display("FAIL sb_write: got rd=%0d wdata=%h, required head of alu queue (%0d left) or mem queue (%0d left)",
                         rd, wdata, q_alu.size(), q_mem.size());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of offers, record accepted non-x0 writes, advance past the edge.
    task automatic drive(input bit av, input logic [4:0] ard, input logic [31:0] adat,
                         input bit mv, input logic [4:0] mrd, input logic [31:0] mdat,
                         output bit a_acc, output bit m_acc);
        alu_valid = av; alu_rd = ard; alu_data = adat;
        mem_valid = mv; mem_rd = mrd; mem_data = mdat;
        #0;
        a_acc = av && alu_ready;
        m_acc = mv && mem_ready;
        if (a_acc && ard != 5'd0) q_alu.push_back('{rd: ard, data: adat});
        if (m_acc && mrd != 5'd0) q_mem.push_back('{rd: mrd, data: mdat});
        step();
    endtask

    task automatic test_reset();
        bit a, m;
        #3;
        n_vec++; if (alu_ready !== 1'b0) begin n_err++; $display("FAIL rst_alu_ready: got %b required 0", alu_ready); end
        n_vec++; if (mem_ready !== 1'b0) begin n_err++; $display("FAIL rst_mem_ready: got %b required 0", mem_ready); end
        n_vec++; if ({RegWrite, rd, wdata} !== '0) begin n_err++; $display("FAIL rst_port: got RegWrite=%b rd=%0d wdata=%h required zeros", RegWrite, rd, wdata); end
        n_vec++; if (pending !== 32'h0) begin n_err++; $display("FAIL rst_pending: got %h required 0", pending); end
        n_vec++; if (idle !== 1'b1) begin n_err++; $display("FAIL rst_idle: got %b required 1", idle); end
        @(posedge clk); #1 rst = 1'b0; #1;
        n_vec++; if ({alu_ready, mem_ready} !== 2'b11) begin n_err++; $display("FAIL post_rst_ready: got %b required 11", {alu_ready, mem_ready}); end
        // Queue two ALU entries behind a MEM write that wins the first contest.
        drive(1, 5'd11, 32'hA0000011, 1, 5'd13, 32'hB0000013, a, m);
        drive(1, 5'd12, 32'hA0000012, 0, 5'd0, 32'h0, a, m);
        alu_valid = 1'b0;
        n_vec++; if (alu_ready !== 1'b0) begin n_err++; $display("FAIL alu_full_ready: got %b required 0", alu_ready); end
        #2 rst = 1'b1;
        #1;
        n_vec++; if ({alu_ready, mem_ready} !== 2'b00) begin n_err++; $display("FAIL midrst_ready: got %b required 00", {alu_ready, mem_ready}); end
        n_vec++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL midrst_regwrite: got %b required 0", RegWrite); end
        n_vec++; if (pending !== 32'h0) begin n_err++; $display("FAIL midrst_pending: got %h required 0", pending); end
        @(posedge clk); #1 rst = 1'b0;
        q_alu.delete(); q_mem.delete();
        for (int i = 0; i < 6; i++) begin
            step();
            n_vec++;
            if (RegWrite !== 1'b0 || idle !== 1'b1) begin
                n_err++; $display("FAIL post_rst_quiet: cycle %0d got RegWrite=%b idle=%b required 0/1", i, RegWrite, idle);
            end
        end
        mon_en = 1'b1;
    endtask

    task automatic test_single_alu();
        bit a, m;
        drive(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0, a, m);   // edge k
        alu_valid = 1'b0;
        n_vec++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL single_k_regwrite: got %b required 0", RegWrite); end
        n_vec++; if (pending[5] !== SB) begin n_err++; $display("FAIL single_k_pending: got %b required %b", pending[5], SB); end
        step();                                                 // edge k+1
        n_vec++; if ({RegWrite, rd, wdata} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
            n_err++; $display("FAIL single_k1_port: got RegWrite=%b rd=%0d wdata=%h required 1/5/deadbeef", RegWrite, rd, wdata); end
        n_vec++; if (pending[5] !== SB) begin n_err++; $display("FAIL single_k1_pending: got %b required %b", pending[5], SB); end
        step();                                                 // edge k+2
        n_vec++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL single_k2_regwrite: got %b required 0", RegWrite); end
        n_vec++; if (pending[5] !== 1'b0) begin n_err++; $display("FAIL single_k2_pending: got %b required 0", pending[5]); end
        n_vec++; if (idle !== 1'b1) begin n_err++; $display("FAIL single_idle: got %b required 1", idle); end
    endtask

    task automatic test_simultaneous();
        bit a, m;
        logic [4:0]  exp_rd [4];
        logic [31:0] exp_wd [4];
        exp_rd[0] = 5'd4; exp_wd[0] = 32'h22;   // MEM wins first contest
        exp_rd[1] = 5'd3; exp_wd[1] = 32'h11;   // then ALU wins the next contest
        exp_rd[2] = 5'd4; exp_wd[2] = 32'h44;
        exp_rd[3] = 5'd3; exp_wd[3] = 32'h33;
        drive(1, 5'd3, 32'h11, 1, 5'd4, 32'h22, a, m);
        drive(1, 5'd3, 32'h33, 1, 5'd4, 32'h44, a, m);
        alu_valid = 1'b0; mem_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if ({RegWrite, rd, wdata} !== {1'b1, exp_rd[i], exp_wd[i]}) begin
                n_err++; $display("FAIL simul_order[%0d]: got RegWrite=%b rd=%0d wdata=%h required 1/%0d/%h",
                                  i, RegWrite, rd, wdata, exp_rd[i], exp_wd[i]);
            end
            step();
        end
        n_vec++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL simul_done: got RegWrite=%b required 0", RegWrite); end
    endtask

    task automatic test_backpressure();
        bit a, m;
        int ai = 0, mi = 0, cyc = 0;
        bit saw_low = 1'b0;
        while ((ai < 8 || mi < 4) && cyc < 100) begin
            if (mi < 4 && !mem_ready) saw_low = 1'b1;
            drive(ai < 8, 5'(16 + ai), 32'hA0000000 + 32'(ai),
                  mi < 4, 5'(8 + mi),  32'hB0000000 + 32'(mi), a, m);
            if (a) ai++;
            if (m) mi++;
            cyc++;
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        for (int i = 0; i < 20 && !idle; i++) step();
        n_vec++; if (saw_low !== 1'b1) begin n_err++; $display("FAIL bp_mem_ready_low: got %b required 1", saw_low); end
        n_vec++; if (ai != 8 || mi != 4) begin n_err++; $display("FAIL bp_accepts: got alu=%0d mem=%0d required 8/4", ai, mi); end
        n_vec++; if (q_mem.size() != 0) begin n_err++; $display("FAIL bp_mem_drained: got %0d left required 0", q_mem.size()); end
        n_vec++; if (q_alu.size() != 0) begin n_err++; $display("FAIL bp_alu_drained: got %0d left required 0", q_alu.size()); end
    endtask

    task automatic test_x0();
        bit a, m;
        logic [31:0] pend_before;
        pend_before = pending;
        drive(1, 5'd0, 32'h1234, 0, 5'd0, 32'h0, a, m);
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, a, m);
        n_vec++; if ({RegWrite, rd, wdata} !== {1'b0, 5'd0, 32'h1234}) begin
            n_err++; $display("FAIL x0_port: got RegWrite=%b rd=%0d wdata=%h required 0/0/1234", RegWrite, rd, wdata); end
        n_vec++; if (pending !== pend_before) begin n_err++; $display("FAIL x0_pending: got %h required %h", pending, pend_before); end
        step();
        n_vec++; if ({RegWrite, wdata} !== {1'b0, 32'h1234}) begin
            n_err++; $display("FAIL x0_hold: got RegWrite=%b wdata=%h required 0/1234", RegWrite, wdata); end
    endtask

    task automatic test_dup_rd();
        bit a, m;
        bit exp_p [5] = '{1, 1, 1, 1, 0};
        for (int i = 0; i < 5; i++) begin
            if (i < 3) drive(1, 5'd7, 32'h71 + 32'(i), 0, 5'd0, 32'h0, a, m);
            else       drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, a, m);
            n_vec++;
            if (pending[7] !== (exp_p[i] & SB)) begin
                n_err++; $display("FAIL dup_pending7[%0d]: got %b required %b", i, pending[7], exp_p[i] & SB);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_simultaneous();
        test_backpressure();
        test_x0();
        test_dup_rd();
        for (int i = 0; i < 4; i++) step();
        n_vec++;
        if (q_alu.size() != 0 || q_mem.size() != 0 || idle !== 1'b1) begin
            n_err++; $display("FAIL final_drain: got alu=%0d mem=%0d idle=%b required 0/0/1", q_alu.size(), q_mem.size(), idle);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
